// File: rtl/pixel_move_pkg.sv
// Shared types and constants for the sprite key-move scheduler.
//   - direction bit indices (UP/DOWN/LEFT/RIGHT), one-hot dir_e
//   - move_state_e scheduler FSM states
//   - POS_W edge-position width, default visible-area limits
package pixel_move_pkg;

  localparam int UP    = 3;
  localparam int DOWN  = 2;
  localparam int LEFT  = 1;
  localparam int RIGHT = 0;

  localparam int POS_W     = 11;
  localparam int H_MAX_DEF = 639;
  localparam int V_MAX_DEF = 479;

  typedef enum logic [3:0] {
    DIR_NONE  = 4'b0000,
    DIR_RIGHT = 4'b0001,
    DIR_LEFT  = 4'b0010,
    DIR_DOWN  = 4'b0100,
    DIR_UP    = 4'b1000
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_DELAY,
    S_REPEAT
  } move_state_e;

  // A single held key selects a direction; nothing or a chord selects NONE.
  function automatic dir_e resolve_dir(input logic [3:0] held);
    case (held)
      4'b0001: return DIR_RIGHT;
      4'b0010: return DIR_LEFT;
      4'b0100: return DIR_DOWN;
      4'b1000: return DIR_UP;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/key_move_scheduler_if.sv
// Bundle between the button/frame/sprite-position sources and the scheduler.
//   key_raw      : raw buttons {up,down,left,right}, asynchronous
//   frame_tick   : one-cycle pulse per frame
//   pixel*_pos   : sprite bounding edges (signed)
//   move         : one-hot one-cycle step pulse
//   held         : debounced key levels
// master drives the inputs and observes move/held; slave is the scheduler.
interface key_move_scheduler_if;
  import pixel_move_pkg::*;

  logic [3:0]              key_raw;
  logic                    frame_tick;
  logic signed [POS_W-1:0] pixel1_row_pos;
  logic signed [POS_W-1:0] pixel2_row_pos;
  logic signed [POS_W-1:0] pixel3_column_pos;
  logic signed [POS_W-1:0] pixel4_column_pos;
  logic [3:0]              move;
  logic [3:0]              held;

  modport master (
    output key_raw, frame_tick,
    output pixel1_row_pos, pixel2_row_pos, pixel3_column_pos, pixel4_column_pos,
    input  move, held
  );

  modport slave (
    input  key_raw, frame_tick,
    input  pixel1_row_pos, pixel2_row_pos, pixel3_column_pos, pixel4_column_pos,
    output move, held
  );
endinterface

// File: rtl/key_move_scheduler_debounce.sv
// One-key conditioner: 2-flop synchroniser then debounce counter.
//   clk, rst : clock, async active-high reset
//   key_i    : raw key, asynchronous
//   held_o   : debounced level
// held_o flips once the synchronised key has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic held_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          held_q, held_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    held_d = held_q;
    cnt_d  = '0;
    if (sync2_q != held_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) held_d = sync2_q;
      else                               cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held_o = held_q;
endmodule

// File: rtl/key_move_scheduler.sv
// Frame-aligned sprite step scheduler with auto-repeat and edge gating.
//   clk, rst : pixel clock, async active-high reset
//   bus      : key_move_scheduler_if.slave (key_raw, frame_tick, sprite
//              edge positions in; move, held out)
// The FSM walks FIRST -> DELAY -> REPEAT on frame ticks; a direction change
// restarts it and swallows a coincident tick. Emitted steps that would push
// the sprite off-screen are dropped from move but still advance the FSM.
module key_move_scheduler
  import pixel_move_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_FRAMES = 15,
  parameter int REPEAT_RATE_FRAMES  = 4,
  parameter int H_MAX               = H_MAX_DEF,
  parameter int V_MAX               = V_MAX_DEF
) (
  input logic             clk,
  input logic             rst,
  key_move_scheduler_if.slave bus
);
  localparam int DLY_W = (REPEAT_DELAY_FRAMES > 1) ? $clog2(REPEAT_DELAY_FRAMES) : 1;
  localparam int RTE_W = (REPEAT_RATE_FRAMES  > 1) ? $clog2(REPEAT_RATE_FRAMES)  : 1;

  localparam logic signed [POS_W-1:0] POS_ZERO = '0;
  localparam logic signed [POS_W-1:0] H_LIM    = POS_W'(H_MAX);
  localparam logic signed [POS_W-1:0] V_LIM    = POS_W'(V_MAX);

  logic [3:0] held;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .key_i  (bus.key_raw[i]),
      .held_o (held[i])
    );
  end

  dir_e        dir, dir_q;
  move_state_e state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [RTE_W-1:0] rte_q, rte_d;
  logic        emit, step_ok;
  logic [3:0]  move_q, move_d;

  assign dir = resolve_dir(held);

  always_comb begin
    case (dir)
      DIR_UP:    step_ok = bus.pixel1_row_pos    > POS_ZERO;
      DIR_DOWN:  step_ok = bus.pixel2_row_pos    < V_LIM;
      DIR_LEFT:  step_ok = bus.pixel3_column_pos > POS_ZERO;
      DIR_RIGHT: step_ok = bus.pixel4_column_pos < H_LIM;
      default:   step_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    rte_d   = rte_q;
    emit    = 1'b0;
    if (dir != dir_q) begin
      // Direction change wins outright, including over a same-cycle tick.
      state_d = (dir == DIR_NONE) ? S_IDLE : S_FIRST;
      dly_d   = '0;
      rte_d   = '0;
    end else if (bus.frame_tick) begin
      case (state_q)
        S_FIRST: begin
          emit    = 1'b1;
          state_d = S_DELAY;
          dly_d   = '0;
        end
        S_DELAY: begin
          if (dly_q == DLY_W'(REPEAT_DELAY_FRAMES - 1)) begin
            emit    = 1'b1;
            state_d = S_REPEAT;
            rte_d   = '0;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
        S_REPEAT: begin
          if (rte_q == RTE_W'(REPEAT_RATE_FRAMES - 1)) begin
            emit  = 1'b1;
            rte_d = '0;
          end else begin
            rte_d = rte_q + RTE_W'(1);
          end
        end
        default: ;
      endcase
    end
    move_d = (emit && step_ok) ? 4'(dir) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_NONE;
      dly_q   <= '0;
      rte_q   <= '0;
      move_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir;
      dly_q   <= dly_d;
      rte_q   <= rte_d;
      move_q  <= move_d;
    end
  end

  assign bus.move = move_q;
  assign bus.held = held;
endmodule
